// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer: accepts FFT samples in bit-reversed order and emits each frame in natural order.
// Latency: first natural-order word appears one enabled edge after the last sample of a frame is captured.
// No backpressure: input rate never exceeds output rate. en=0 freezes everything. Optional d_sof via REORDER_SOF_EN.
module bit_reverse_reorder #(
   parameter int vector_size = 16,
   parameter int log2_n      = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [vector_size-1:0] d_in,
   output logic [vector_size-1:0] d_out,
   output logic                   d_valid
`ifdef REORDER_SOF_EN
   ,
   output logic                   d_sof
`endif
);

   localparam int N = 1 << log2_n;
   localparam logic [log2_n-1:0] last_idx = '1;
   localparam logic [log2_n-1:0] one_idx  = log2_n'(1);

   // Two banks of N words; contents need no reset because full[] gates every read.
   logic [vector_size-1:0] mem [2][N];

   logic [log2_n-1:0] wcnt;
   logic [log2_n-1:0] rcnt;
   logic              wbank;
   logic              rbank;
   logic [1:0]        full;
   logic [1:0]        full_nxt;

   logic wr_fire;
   logic wr_last;
   logic rd_fire;
   logic rd_last;

   // Reverse the log2_n index bits so bit-reversed input lands at its natural slot.
   function automatic logic [log2_n-1:0] bitrev(input logic [log2_n-1:0] j);
      logic [log2_n-1:0] r;
      for (int b = 0; b < log2_n; b++) begin
         r[b] = j[log2_n-1-b];
      end
      return r;
   endfunction

   assign wr_fire = en & in_valid;
   assign wr_last = wr_fire & (wcnt == last_idx);
   assign rd_fire = en & full[rbank];
   assign rd_last = rd_fire & (rcnt == last_idx);

   // Bank-full flags: writer completion and reader completion hit different bits, so both apply.
   always_comb begin
      full_nxt = full;
      if (wr_last) begin
         full_nxt[wbank] = 1'b1;
      end
      if (rd_last) begin
         full_nxt[rbank] = 1'b0;
      end
   end

   // Sample storage: scatter each input to its bit-reversed address in the write bank.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wbank][bitrev(wcnt)] <= d_in;
      end
   end

   // Write/read counters, bank pointers, full flags and registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt    <= '0;
         wbank   <= 1'b0;
         rcnt    <= '0;
         rbank   <= 1'b0;
         full    <= 2'b00;
         d_out   <= '0;
         d_valid <= 1'b0;
      end else if (en) begin
         full <= full_nxt;
         if (in_valid) begin
            wcnt <= wcnt + one_idx;
            if (wcnt == last_idx) begin
               wbank <= ~wbank;
            end
         end
         if (full[rbank]) begin
            d_out   <= mem[rbank][rcnt];
            d_valid <= 1'b1;
            rcnt    <= rcnt + one_idx;
            if (rcnt == last_idx) begin
               rbank <= ~rbank;
            end
         end else begin
            d_valid <= 1'b0;
         end
      end
   end

`ifdef REORDER_SOF_EN
   // Start-of-frame marker accompanies the read of natural index 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_sof <= 1'b0;
      end else if (en) begin
         d_sof <= full[rbank] & (rcnt == '0);
      end
   end
`endif

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Bench for bit_reverse_reorder: directed frames plus randomized en/in_valid/reset traffic.
// Reference model works on whole frames (queue of pending natural-order words), checked every cycle.
// d_sof is checked too when REORDER_SOF_EN is defined.
module tb_bit_reverse_reorder;

   localparam int W = 16;
   localparam int L = 3;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         in_valid;
   logic [W-1:0] d_in;
   logic [W-1:0] d_out;
   logic         d_valid;
`ifdef REORDER_SOF_EN
   logic         d_sof;
`endif

   always #5 clk = ~clk;

   bit_reverse_reorder #(.vector_size(W), .log2_n(L)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .in_valid (in_valid),
      .d_in     (d_in),
      .d_out    (d_out),
      .d_valid  (d_valid)
`ifdef REORDER_SOF_EN
      ,
      .d_sof    (d_sof)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference state: words waiting to be emitted, their sof flags, the partial input frame.
   logic [W-1:0] exp_q [$];
   bit           sof_q [$];
   logic [W-1:0] part_q[$];
   logic [W-1:0] out_log[$];
   logic [W-1:0] m_dout;
   bit           m_dvld;
   bit           m_sof;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Arithmetic bit reversal of an L-bit index.
   function automatic int rev(input int j);
      int r;
      r = 0;
      for (int b = 0; b < L; b++) begin
         r = r * 2 + ((j >> b) & 1);
      end
      return r;
   endfunction

   // One clock: drive inputs, advance the model for this edge, compare just after the edge.
   task automatic cycle(input bit r, input bit e, input bit v, input logic [W-1:0] d);
      reset    = r;
      en       = e;
      in_valid = v;
      d_in     = d;
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         sof_q.delete();
         part_q.delete();
         m_dout = '0;
         m_dvld = 1'b0;
         m_sof  = 1'b0;
      end else if (e) begin
         if (exp_q.size() > 0) begin
            m_dout = exp_q.pop_front();
            m_sof  = sof_q.pop_front();
            m_dvld = 1'b1;
         end else begin
            m_dvld = 1'b0;
            m_sof  = 1'b0;
         end
         if (v) begin
            part_q.push_back(d);
            if (part_q.size() == N) begin
               for (int i = 0; i < N; i++) begin
                  exp_q.push_back(part_q[rev(i)]);
                  sof_q.push_back(i == 0);
               end
               part_q.delete();
            end
         end
      end
      check_val("d_valid", 32'(d_valid), 32'(m_dvld));
      check_val("d_out", 32'(d_out), 32'(m_dout));
`ifdef REORDER_SOF_EN
      check_val("d_sof", 32'(d_sof), 32'(m_sof));
`endif
      if (!r && e && d_valid === 1'b1) begin
         out_log.push_back(d_out);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0);
      end
   endtask

   logic [W-1:0] ref_a [8];
   logic [W-1:0] ref_b [8];

   initial begin
      ref_a = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
      ref_b = '{16'd100, 16'd104, 16'd102, 16'd106, 16'd101, 16'd105, 16'd103, 16'd107};
      m_dout = '0;
      m_dvld = 1'b0;
      m_sof  = 1'b0;

      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);

      // Single frame 0..7 and its known natural-order result.
      out_log.delete();
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 1'b1, W'(i));
      idle(10);
      check_val("frame_a_len", 32'(out_log.size()), 32'(N));
      for (int i = 0; i < N && i < out_log.size(); i++) check_val("frame_a_val", 32'(out_log[i]), 32'(ref_a[i]));

      // Three back-to-back frames 0..23.
      for (int i = 0; i < 3 * N; i++) cycle(1'b0, 1'b1, 1'b1, W'(i));
      idle(10);

      // Same frame with in_valid on every other cycle.
      for (int i = 0; i < 2 * N; i++) cycle(1'b0, 1'b1, (i % 2) == 0, W'(i / 2));
      idle(10);

      // en low for 3 cycles in the middle of the output burst.
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 1'b1, W'(i + 40));
      idle(3);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);
      idle(8);

      // Reset after 5 of 8 samples, then a fresh frame 100..107.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, W'(i + 60));
      cycle(1'b1, 1'b1, 1'b0, '0);
      out_log.delete();
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 1'b1, W'(i + 100));
      idle(10);
      check_val("frame_b_len", 32'(out_log.size()), 32'(N));
      for (int i = 0; i < N && i < out_log.size(); i++) check_val("frame_b_val", 32'(out_log[i]), 32'(ref_b[i]));

      // Randomized traffic with en gaps, input gaps and rare resets.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 2) != 0, W'($urandom));
      end
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
